// File: rtl/muldiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_pkg - MulDiv function codes, issuer state encoding, default widths.
// Rev 1.0
// ---------------------------------------------------------------------------
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned TAG_W_DEFAULT = 5;

  localparam logic [3:0] FN_MUL    = 4'd0;
  localparam logic [3:0] FN_MULH   = 4'd1;
  localparam logic [3:0] FN_MULHSU = 4'd2;
  localparam logic [3:0] FN_MULHU  = 4'd3;
  localparam logic [3:0] FN_DIV    = 4'd4;
  localparam logic [3:0] FN_DIVU   = 4'd5;
  localparam logic [3:0] FN_REM    = 4'd6;
  localparam logic [3:0] FN_REMU   = 4'd7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    KILLWIN = 3'd2,
    WAIT    = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_lat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_lat_counter - saturating latency counter, terminal count at TIMEOUT.
// Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_lat_counter #(
  parameter int unsigned LAT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [LAT_W-1:0] count_o,
  output logic             tc_o
);

  localparam logic [LAT_W-1:0] CNT_MAX = '1;
  localparam logic [LAT_W-1:0] CNT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] CNT_TC  = LAT_W'(TIMEOUT);

  logic [LAT_W-1:0] count_q;
  logic [LAT_W-1:0] count_d;

  // clear together with enable restarts at 1 so the fire cycle itself counts
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = en_i ? CNT_ONE : '0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q >= CNT_TC);

endmodule
`default_nettype wire

// File: rtl/muldiv_issuer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_issuer - single-outstanding MulDiv request initiator with kill window,
// response timeout and latency report. Optional MULDIV_ISSUER_STATS_EN adds
// saturating done/killed/timeout counters. Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_issuer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned TAG_W   = TAG_W_DEFAULT,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned LAT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_fn,
  input  logic             cmd_dw,
  input  logic [XLEN-1:0]  cmd_in1,
  input  logic [XLEN-1:0]  cmd_in2,
  input  logic             cmd_abort,
  output logic             io_req_valid,
  input  logic             io_req_ready,
  output logic [3:0]       io_req_bits_fn,
  output logic             io_req_bits_dw,
  output logic [XLEN-1:0]  io_req_bits_in1,
  output logic [XLEN-1:0]  io_req_bits_in2,
  output logic [TAG_W-1:0] io_req_bits_tag,
  output logic             io_kill,
  input  logic             io_resp_valid,
  output logic             io_resp_ready,
  input  logic [XLEN-1:0]  io_resp_bits_data,
  input  logic [TAG_W-1:0] io_resp_bits_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [LAT_W-1:0] res_latency,
  output logic             err_timeout,
  output logic             err_tag
`ifdef MULDIV_ISSUER_STATS_EN
  ,
  output logic [15:0]      stat_done,
  output logic [15:0]      stat_killed,
  output logic [15:0]      stat_timeout
`endif
);

  state_e           state_q;
  logic             cmd_ready_q;
  logic             req_valid_q;
  logic             resp_ready_q;
  logic             res_valid_q;
  logic [3:0]       fn_q;
  logic             dw_q;
  logic [XLEN-1:0]  in1_q;
  logic [XLEN-1:0]  in2_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  res_data_q;
  logic [TAG_W-1:0] res_tag_q;
  logic [LAT_W-1:0] res_lat_q;
  logic             err_timeout_q;
  logic             err_tag_q;

  logic             cmd_fire;
  logic             req_fire;
  logic             resp_fire;
  logic             res_fire;
  logic             in_flight;
  logic             kill_evt;
  logic             done_evt;
  logic             tmo_evt;
  logic [LAT_W-1:0] lat_count;
  logic             lat_tc;

  assign cmd_fire  = cmd_valid & cmd_ready_q;
  assign req_fire  = req_valid_q & io_req_ready;
  assign resp_fire = io_resp_valid & resp_ready_q;
  assign res_fire  = res_valid_q & res_ready;
  assign in_flight = (state_q == KILLWIN) || (state_q == WAIT);

  // Kill beats a coincident response; a response beats a coincident timeout.
  assign kill_evt = (state_q == KILLWIN) & cmd_abort;
  assign done_evt = in_flight & resp_fire & ~kill_evt;
  assign tmo_evt  = (state_q == WAIT) & ~resp_fire & lat_tc;

  muldiv_lat_counter #(
    .LAT_W   (LAT_W),
    .TIMEOUT (TIMEOUT)
  ) u_lat_counter (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (req_fire),
    .en_i    (req_fire | in_flight),
    .count_o (lat_count),
    .tc_o    (lat_tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      req_valid_q   <= 1'b0;
      resp_ready_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      fn_q          <= '0;
      dw_q          <= 1'b0;
      in1_q         <= '0;
      in2_q         <= '0;
      tag_q         <= '0;
      res_data_q    <= '0;
      res_tag_q     <= '0;
      res_lat_q     <= '0;
      err_timeout_q <= 1'b0;
      err_tag_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            fn_q          <= cmd_fn;
            dw_q          <= cmd_dw;
            in1_q         <= cmd_in1;
            in2_q         <= cmd_in2;
            err_timeout_q <= 1'b0;
            cmd_ready_q   <= 1'b0;
            req_valid_q   <= 1'b1;
            state_q       <= REQ;
          end
        end
        REQ: begin
          if (req_fire) begin
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
            state_q      <= KILLWIN;
          end
        end
        KILLWIN, WAIT: begin
          if (kill_evt || tmo_evt) begin
            tag_q        <= tag_q + 1'b1;
            resp_ready_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            state_q      <= IDLE;
            if (tmo_evt) begin
              err_timeout_q <= 1'b1;
            end
          end else if (done_evt) begin
            res_data_q   <= io_resp_bits_data;
            res_tag_q    <= io_resp_bits_tag;
            res_lat_q    <= lat_count;
            tag_q        <= tag_q + 1'b1;
            resp_ready_q <= 1'b0;
            res_valid_q  <= 1'b1;
            state_q      <= DONE;
            if (io_resp_bits_tag != tag_q) begin
              err_tag_q <= 1'b1;
            end
          end else begin
            state_q <= WAIT;
          end
        end
        DONE: begin
          if (res_fire) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          cmd_ready_q  <= 1'b1;
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b0;
          res_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign io_req_valid    = req_valid_q;
  assign io_req_bits_fn  = fn_q;
  assign io_req_bits_dw  = dw_q;
  assign io_req_bits_in1 = in1_q;
  assign io_req_bits_in2 = in2_q;
  assign io_req_bits_tag = tag_q;
  assign io_kill         = kill_evt;
  assign io_resp_ready   = resp_ready_q;
  assign res_valid       = res_valid_q;
  assign res_data        = res_data_q;
  assign res_tag         = res_tag_q;
  assign res_latency     = res_lat_q;
  assign err_timeout     = err_timeout_q;
  assign err_tag         = err_tag_q;

`ifdef MULDIV_ISSUER_STATS_EN
  logic [15:0] stat_done_q;
  logic [15:0] stat_killed_q;
  logic [15:0] stat_timeout_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_done_q    <= '0;
      stat_killed_q  <= '0;
      stat_timeout_q <= '0;
    end else begin
      if (done_evt && (stat_done_q != 16'hFFFF)) begin
        stat_done_q <= stat_done_q + 16'd1;
      end
      if (kill_evt && (stat_killed_q != 16'hFFFF)) begin
        stat_killed_q <= stat_killed_q + 16'd1;
      end
      if (tmo_evt && (stat_timeout_q != 16'hFFFF)) begin
        stat_timeout_q <= stat_timeout_q + 16'd1;
      end
    end
  end

  assign stat_done    = stat_done_q;
  assign stat_killed  = stat_killed_q;
  assign stat_timeout = stat_timeout_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for muldiv_issuer: stimulus pushes expected results, a
// negedge monitor pops and compares on every result handshake.
module tb_muldiv_issuer;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int LAT_W = 16;
  localparam int TMO   = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_fn = '0;
  logic             cmd_dw = 1'b0;
  logic [XLEN-1:0]  cmd_in1 = '0;
  logic [XLEN-1:0]  cmd_in2 = '0;
  logic             cmd_abort = 1'b0;
  logic             io_req_valid;
  logic             io_req_ready = 1'b0;
  logic [3:0]       io_req_bits_fn;
  logic             io_req_bits_dw;
  logic [XLEN-1:0]  io_req_bits_in1;
  logic [XLEN-1:0]  io_req_bits_in2;
  logic [TAG_W-1:0] io_req_bits_tag;
  logic             io_kill;
  logic             io_resp_valid = 1'b0;
  logic             io_resp_ready;
  logic [XLEN-1:0]  io_resp_bits_data = '0;
  logic [TAG_W-1:0] io_resp_bits_tag = '0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [XLEN-1:0]  res_data;
  logic [TAG_W-1:0] res_tag;
  logic [LAT_W-1:0] res_latency;
  logic             err_timeout;
  logic             err_tag;

  muldiv_issuer #(
    .XLEN(XLEN), .TAG_W(TAG_W), .TIMEOUT(TMO), .LAT_W(LAT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fn(cmd_fn), .cmd_dw(cmd_dw),
    .cmd_in1(cmd_in1), .cmd_in2(cmd_in2), .cmd_abort(cmd_abort),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_bits_fn(io_req_bits_fn), .io_req_bits_dw(io_req_bits_dw),
    .io_req_bits_in1(io_req_bits_in1), .io_req_bits_in2(io_req_bits_in2),
    .io_req_bits_tag(io_req_bits_tag), .io_kill(io_kill),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_bits_data(io_resp_bits_data), .io_resp_bits_tag(io_resp_bits_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_latency(res_latency),
    .err_timeout(err_timeout), .err_tag(err_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
    logic [LAT_W-1:0] lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   req_fires = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: result handshakes and request fires, sampled mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (reset && io_req_valid && io_req_ready) req_fires++;
    if (reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL res_unexpected: got data=0x%0h tag=%0d, expected no result", res_data, res_tag);
      end else begin
        e = exp_q.pop_front();
        check("res_data", 64'(res_data), 64'(e.data));
        check("res_tag", 64'(res_tag), 64'(e.tag));
        check("res_latency", 64'(res_latency), 64'(e.lat));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: cmd_ready still 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic issue(input logic [3:0] fn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    wait_idle();
    cmd_valid = 1'b1;
    cmd_fn    = fn;
    cmd_dw    = 1'b1;
    cmd_in1   = a;
    cmd_in2   = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Holds io_req_ready low for 'hold' cycles while scrambling the cmd pins.
  task automatic fire_req(input int hold, input logic [3:0] fn, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    check("req_valid", 64'(io_req_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_in1   = ~a;
      cmd_in2   = b ^ 32'h5A5A_5A5A;
      tick();
      check("hold_req_valid", 64'(io_req_valid), 64'd1);
      check("hold_in1", 64'(io_req_bits_in1), 64'(a));
      check("hold_in2", 64'(io_req_bits_in2), 64'(b));
    end
    cmd_valid = 1'b0;
    check("req_fn", 64'(io_req_bits_fn), 64'(fn));
    check("req_dw", 64'(io_req_bits_dw), 64'd1);
    check("req_in1", 64'(io_req_bits_in1), 64'(a));
    check("req_in2", 64'(io_req_bits_in2), 64'(b));
    check("req_tag", 64'(io_req_bits_tag), 64'(tag));
    io_req_ready = 1'b1;
    tick();
    io_req_ready = 1'b0;
  endtask

  // Called in the KILLWIN cycle; response fires 'lat' edges after req fire.
  task automatic respond(input int lat, input logic [XLEN-1:0] data,
                         input logic [TAG_W-1:0] tag, input logic abort_in_wait);
    for (int i = 1; i < lat; i++) begin
      tick();
      cmd_abort = abort_in_wait;
      #1;
      check("wait_no_kill", 64'(io_kill), 64'd0);
    end
    io_resp_valid     = 1'b1;
    io_resp_bits_data = data;
    io_resp_bits_tag  = tag;
    tick();
    io_resp_valid = 1'b0;
    cmd_abort     = 1'b0;
  endtask

  task automatic op(input logic [3:0] fn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                    input logic [TAG_W-1:0] tag, input int lat, input logic [XLEN-1:0] data);
    issue(fn, a, b);
    fire_req(0, fn, a, b, tag);
    exp_q.push_back('{data: data, tag: tag, lat: LAT_W'(lat)});
    respond(lat, data, tag, 1'b0);
    wait_idle();
  endtask

  initial begin
    int n;
    int fires0;
    logic [TAG_W-1:0] t;

    // Reset state
    #12;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_req_valid", 64'(io_req_valid), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_resp_ready", 64'(io_resp_ready), 64'd0);
    check("rst_kill", 64'(io_kill), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
    check("rst_err_tag", 64'(err_tag), 64'd0);
    check("rst_tag", 64'(io_req_bits_tag), 64'd0);
    #10;
    reset = 1'b1;
    tick();

    // MUL 7*6, latency 3, with the result held under backpressure
    issue(4'd0, 32'd7, 32'd6);
    fire_req(0, 4'd0, 32'd7, 32'd6, 5'd0);
    res_ready = 1'b0;
    exp_q.push_back('{data: 32'd42, tag: 5'd0, lat: 16'd3});
    respond(3, 32'd42, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("done_hold_valid", 64'(res_valid), 64'd1);
      check("done_hold_data", 64'(res_data), 64'd42);
      check("done_cmd_ready", 64'(cmd_ready), 64'd0);
      tick();
    end
    res_ready = 1'b1;
    wait_idle();

    op(4'd4, 32'd100, 32'd7, 5'd1, 2, 32'd14);   // DIV
    op(4'd6, 32'd100, 32'd7, 5'd2, 1, 32'd2);    // REM, response in the kill window

    // Request backpressure: fields hold, one fire only
    fires0 = req_fires;
    issue(4'd0, 32'd3, 32'd5);
    fire_req(5, 4'd0, 32'd3, 32'd5, 5'd3);
    exp_q.push_back('{data: 32'd15, tag: 5'd3, lat: 16'd2});
    respond(2, 32'd15, 5'd3, 1'b0);
    wait_idle();
    check("bp_req_fires", 64'(req_fires - fires0), 64'd1);

    // Kill in the window after req fire
    issue(4'd5, 32'd100, 32'd7);
    fire_req(0, 4'd5, 32'd100, 32'd7, 5'd4);
    cmd_abort = 1'b1;
    #1;
    check("kill_pulse", 64'(io_kill), 64'd1);
    tick();
    cmd_abort = 1'b0;
    #1;
    check("kill_one_cycle", 64'(io_kill), 64'd0);
    check("kill_cmd_ready", 64'(cmd_ready), 64'd1);
    check("kill_res_valid", 64'(res_valid), 64'd0);
    check("kill_tag_inc", 64'(io_req_bits_tag), 64'd5);

    // Kill coincident with a response: response dropped
    issue(4'd5, 32'd100, 32'd7);
    fire_req(0, 4'd5, 32'd100, 32'd7, 5'd5);
    cmd_abort         = 1'b1;
    io_resp_valid     = 1'b1;
    io_resp_bits_data = 32'd14;
    io_resp_bits_tag  = 5'd5;
    #1;
    check("killresp_kill", 64'(io_kill), 64'd1);
    tick();
    cmd_abort     = 1'b0;
    io_resp_valid = 1'b0;
    tick();
    check("killresp_res_valid", 64'(res_valid), 64'd0);
    check("killresp_tag", 64'(io_req_bits_tag), 64'd6);

    // Abort while waiting is ignored (MULHU 0xFFFFFFFF*2 high word = 1)
    issue(4'd3, 32'hFFFF_FFFF, 32'd2);
    fire_req(0, 4'd3, 32'hFFFF_FFFF, 32'd2, 5'd6);
    exp_q.push_back('{data: 32'd1, tag: 5'd6, lat: 16'd4});
    respond(4, 32'd1, 5'd6, 1'b1);
    wait_idle();

    // Timeout: silent responder
    issue(4'd0, 32'd9, 32'd9);
    fire_req(0, 4'd0, 32'd9, 32'd9, 5'd7);
    n = 0;
    while (!err_timeout && n < 20) begin
      tick();
      n++;
    end
    check("tmo_cycles", 64'(n), 64'd8);
    check("tmo_err", 64'(err_timeout), 64'd1);
    check("tmo_cmd_ready", 64'(cmd_ready), 64'd1);
    check("tmo_resp_ready", 64'(io_resp_ready), 64'd0);
    check("tmo_tag_inc", 64'(io_req_bits_tag), 64'd8);

    // Next command clears the error; response exactly at TIMEOUT wins
    issue(4'd7, 32'd10, 32'd3);
    check("tmo_cleared", 64'(err_timeout), 64'd0);
    fire_req(0, 4'd7, 32'd10, 32'd3, 5'd8);
    exp_q.push_back('{data: 32'd1, tag: 5'd8, lat: 16'd8});
    respond(8, 32'd1, 5'd8, 1'b0);
    wait_idle();
    check("tmo_edge_no_err", 64'(err_timeout), 64'd0);

    // 33 ops across the tag wrap
    for (int k = 0; k < 33; k++) begin
      t = TAG_W'(9 + k);
      op(4'd0, 32'(k), 32'd3, t, 1, 32'(k * 3));
    end

    // Wrong response tag: flagged, result still delivered
    check("pre_err_tag", 64'(err_tag), 64'd0);
    issue(4'd1, 32'd2, 32'd3);
    fire_req(0, 4'd1, 32'd2, 32'd3, 5'd10);
    exp_q.push_back('{data: 32'd0, tag: 5'd11, lat: 16'd2});
    respond(2, 32'd0, 5'd11, 1'b0);
    wait_idle();
    check("err_tag_set", 64'(err_tag), 64'd1);

    // Asynchronous reset while waiting
    issue(4'd0, 32'd1, 32'd1);
    fire_req(0, 4'd0, 32'd1, 32'd1, 5'd11);
    tick();
    check("wait_resp_ready", 64'(io_resp_ready), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_req_valid", 64'(io_req_valid), 64'd0);
    check("arst_resp_ready", 64'(io_resp_ready), 64'd0);
    check("arst_res_valid", 64'(res_valid), 64'd0);
    check("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("arst_err_tag", 64'(err_tag), 64'd0);
    check("arst_tag", 64'(io_req_bits_tag), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("results_outstanding", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
